axi4_stream_pkt_sel: RTL



---
 rtl/axi4_stream_if.sv | 63 ++++++
 rtl/axi4_stream_pkt_sel.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/axi4_stream_if.sv
// ---------------------------------------------------------------------------
// axi4_stream_if
//
// Purpose:
//   Bundle of AXI4-Stream handshake and payload signals shared by a producer
//   and a consumer. Each beat carries DN data elements of type DT. It also
//   carries one TKEEP bit per element and a TLAST packet delimiter.
//
// Signals:
//   tdata   DN x DT  payload elements
//   tkeep   DN       per-element keep strobes
//   tlast   1        last beat of a packet
//   tvalid  1        producer has a beat on the bus
//   tready  1        consumer can take the beat
//
// Modports:
//   s / master  producer side (drives payload and tvalid, samples tready)
//   d / slave   consumer side (samples payload and tvalid, drives tready)
// ---------------------------------------------------------------------------
interface axi4_stream_if #(
    parameter int  DN = 1,
    parameter type DT = logic [8-1:0]
) ();

    DT    [DN-1:0] tdata;
    logic [DN-1:0] tkeep;
    logic          tlast;
    logic          tvalid;
    logic          tready;

    modport s (
        output tdata,
        output tkeep,
        output tlast,
        output tvalid,
        input  tready
    );

    modport d (
        input  tdata,
        input  tkeep,
        input  tlast,
        input  tvalid,
        output tready
    );

    modport master (
        output tdata,
        output tkeep,
        output tlast,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tkeep,
        input  tlast,
        input  tvalid,
        output tready
    );

endinterface

// File: rtl/axi4_stream_pkt_sel.sv
// ---------------------------------------------------------------------------
// axi4_stream_pkt_sel
//
// Purpose:
//   Registered, packet-aware select stage placed in front of an AXI4-Stream
//   demux. The requested output port is sampled only on the first beat of a
//   packet. Every beat of that packet is then tagged with the latched select.
//   Each tag travels with its beat through a two-entry (head + skid) buffer.
//   As a result, the downstream demux never switches ports in the middle of a
//   packet. The stream also gets a full register cut on both the data path
//   and tready.
//
// Parameters:
//   SN  number of demux output ports
//   SW  select width
//   DN  data elements per beat
//   DT  data element type
//
// Ports:
//   clk      clock
//   rst      asynchronous, active-high reset
//   sel_req  requested output port, sampled at packet starts only
//   sti      input stream (consumer side)
//   sto      output stream towards the demux (producer side)
//   sel      select tag of the current output beat (demux sel)
//   busy     an input packet has started but its last beat is not yet taken
//   err      sticky flag, set when an out-of-range sel_req is sampled
// ---------------------------------------------------------------------------
module axi4_stream_pkt_sel #(
    parameter int  SN = 2,
    parameter int  SW = $clog2(SN),
    parameter int  DN = 1,
    parameter type DT = logic [8-1:0]
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [SW-1:0] sel_req,
    axi4_stream_if.d      sti,
    axi4_stream_if.s      sto,
    output logic [SW-1:0] sel,
    output logic          busy,
    output logic          err
);

    // Buffer occupancy: nothing held, head only, or head plus skid.
    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        TWO
    } occ_t;

    occ_t occ_q;
    occ_t occ_d;

    DT    [DN-1:0] head_data;
    logic [DN-1:0] head_keep;
    logic          head_last;
    logic [SW-1:0] head_tag;

    DT    [DN-1:0] skid_data;
    logic [DN-1:0] skid_keep;
    logic          skid_last;
    logic [SW-1:0] skid_tag;

    logic          ready_q;
    logic          busy_q;
    logic          err_q;
    logic [SW-1:0] sel_cur;

    logic          accept;
    logic          xfer;
    logic          req_oor;
    logic [SW-1:0] req_clamped;
    logic [SW-1:0] in_tag;

    logic          load_head_in;
    logic          load_head_skid;
    logic          load_skid;

    // Handshake qualifiers. The output is valid whenever the head entry is
    // occupied. The input side uses only the registered ready.
    assign accept     = sti.tvalid & ready_q;
    assign xfer       = sto.tvalid & sto.tready;
    assign sto.tvalid = (occ_q != EMPTY);
    assign sti.tready = ready_q;

    // Range clamp for the requested port. When SN fills the select width
    // exactly, no request can be out of range, so the comparison is left out.
    if (SN == (1 << SW)) begin : g_no_clamp
        assign req_oor     = 1'b0;
        assign req_clamped = sel_req;
    end else begin : g_clamp
        assign req_oor     = (sel_req >= SW'(SN));
        assign req_clamped = req_oor ? SW'(SN - 1) : sel_req;
    end

    // The first beat of a packet takes the freshly clamped request. Later
    // beats reuse the select latched at the packet start.
    assign in_tag = busy_q ? sel_cur : req_clamped;

    // Next-occupancy and buffer steering. In ONE, a simultaneous accept and
    // transfer replaces the head in place. In TWO, the input is stalled, so
    // only a drain of the head, refilled from the skid, can happen.
    always_comb begin
        occ_d          = occ_q;
        load_head_in   = 1'b0;
        load_head_skid = 1'b0;
        load_skid      = 1'b0;
        case (occ_q)
            EMPTY: begin
                if (accept) begin
                    occ_d        = ONE;
                    load_head_in = 1'b1;
                end
            end
            ONE: begin
                if (accept && !xfer) begin
                    occ_d     = TWO;
                    load_skid = 1'b1;
                end else if (!accept && xfer) begin
                    occ_d = EMPTY;
                end else if (accept && xfer) begin
                    load_head_in = 1'b1;
                end
            end
            TWO: begin
                if (xfer) begin
                    occ_d          = ONE;
                    load_head_skid = 1'b1;
                end
            end
            default: begin
                occ_d = EMPTY;
            end
        endcase
    end

    // Occupancy register and registered input ready. Ready reflects
    // "skid will be empty", so it never depends combinationally on sto.tready.
    // It is held low while in reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q   <= EMPTY;
            ready_q <= 1'b0;
        end else begin
            occ_q   <= occ_d;
            ready_q <= (occ_d != TWO);
        end
    end

    // Head entry. On a drain to empty it is left untouched. As a result,
    // head_tag keeps presenting the select of the last transferred beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_data <= '0;
            head_keep <= '0;
            head_last <= 1'b0;
            head_tag  <= '0;
        end else if (load_head_in) begin
            head_data <= sti.tdata;
            head_keep <= sti.tkeep;
            head_last <= sti.tlast;
            head_tag  <= in_tag;
        end else if (load_head_skid) begin
            head_data <= skid_data;
            head_keep <= skid_keep;
            head_last <= skid_last;
            head_tag  <= skid_tag;
        end
    end

    // Skid entry. It catches the beat that arrives while the head is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_data <= '0;
            skid_keep <= '0;
            skid_last <= 1'b0;
            skid_tag  <= '0;
        end else if (load_skid) begin
            skid_data <= sti.tdata;
            skid_keep <= sti.tkeep;
            skid_last <= sti.tlast;
            skid_tag  <= in_tag;
        end
    end

    // Packet tracking. busy marks that a packet is open. The select is
    // latched on the first beat. err records any clamped request and stays
    // set until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q  <= 1'b0;
            sel_cur <= '0;
            err_q   <= 1'b0;
        end else if (accept) begin
            busy_q <= !sti.tlast;
            if (!busy_q) begin
                sel_cur <= req_clamped;
                if (req_oor) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    assign sto.tdata = head_data;
    assign sto.tkeep = head_keep;
    assign sto.tlast = head_last;
    assign sel       = head_tag;
    assign busy      = busy_q;
    assign err       = err_q;

endmodule
